// File: rtl/hazard_ctrl.sv
// Stall/flush generator for the 5-stage pipeline: load-use, redirect,
// fetch wait and D-mem wait with timeout, plus two saturating counters.
module hazard_ctrl #(
    parameter int unsigned DMEM_TIMEOUT = 255,
    parameter int unsigned TO_W         = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_r1,
    input  logic [4:0]  id_r2,
    input  logic        id_r1_used,
    input  logic        id_r2_used,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_re,
    input  logic        ex_redirect,
    input  logic        if_valid,
    input  logic        mem_req,
    input  logic        dmem_ack,
    output logic [4:0]  stall_o,
    output logic [4:0]  flush_o,
    output logic        dmem_err,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_redirect_cnt
);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    localparam logic [TO_W-1:0] TO_VAL = TO_W'(DMEM_TIMEOUT);

    state_t          state;
    state_t          state_nxt;
    logic [TO_W-1:0] wcnt;
    logic [TO_W-1:0] wcnt_nxt;
    logic            timeout;
    logic            dm_wait;
    logic            load_use;
    logic            redir_sel;

    always_comb begin
        timeout = (state == WAIT) && mem_req && !dmem_ack
                  && (wcnt == TO_VAL);
        dm_wait = mem_req && !dmem_ack && !timeout;
        load_use = ex_mem_re && (ex_rd != 5'd0)
                   && ((id_r1_used && (id_r1 == ex_rd))
                    || (id_r2_used && (id_r2 == ex_rd)));
    end

    // Priority chain: only the highest active hazard drives the buses
    always_comb begin
        stall_o   = 5'b00000;
        flush_o   = 5'b00000;
        redir_sel = 1'b0;
        dmem_err  = 1'b0;
        if (rst) begin
            dmem_err = timeout;
            if (dm_wait) begin
                stall_o = 5'b01111;
                flush_o = 5'b10000;
            end else if (ex_redirect) begin
                flush_o   = 5'b00110;
                redir_sel = 1'b1;
            end else if (load_use) begin
                stall_o = 5'b00011;
                flush_o = 5'b00100;
            end else if (!if_valid) begin
                stall_o = 5'b00001;
                flush_o = 5'b00010;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        unique case (state)
            IDLE: begin
                if (mem_req && !dmem_ack) begin
                    state_nxt = WAIT;
                    wcnt_nxt  = TO_W'(1);
                end
            end
            WAIT: begin
                if (dm_wait) begin
                    wcnt_nxt = wcnt + TO_W'(1);
                end else begin
                    state_nxt = IDLE;
                    wcnt_nxt  = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state             <= IDLE;
            wcnt              <= '0;
            perf_stall_cnt    <= '0;
            perf_redirect_cnt <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            if ((stall_o != 5'b00000) && (perf_stall_cnt != '1))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (redir_sel && (perf_redirect_cnt != '1))
                perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expected buses queued at drive time,
// popped and compared once the combinational outputs settle.
module tb_hazard_ctrl;

    localparam int TO = 4;

    localparam logic [4:0] Z    = 5'b00000;
    localparam logic [4:0] S_DM = 5'b01111;
    localparam logic [4:0] F_DM = 5'b10000;
    localparam logic [4:0] F_RD = 5'b00110;
    localparam logic [4:0] S_LU = 5'b00011;
    localparam logic [4:0] F_LU = 5'b00100;
    localparam logic [4:0] S_IF = 5'b00001;
    localparam logic [4:0] F_IF = 5'b00010;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  id_r1, id_r2, ex_rd;
    logic        id_r1_used, id_r2_used;
    logic        ex_mem_re, ex_redirect, if_valid;
    logic        mem_req, dmem_ack;
    logic [4:0]  stall_o, flush_o;
    logic        dmem_err;
    logic [31:0] perf_stall_cnt, perf_redirect_cnt;

    typedef struct packed {
        logic [4:0] st;
        logic [4:0] fl;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   vec = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.DMEM_TIMEOUT(TO), .TO_W(8)) dut (
        .clk(clk), .rst(rst),
        .id_r1(id_r1), .id_r2(id_r2),
        .id_r1_used(id_r1_used), .id_r2_used(id_r2_used),
        .ex_rd(ex_rd), .ex_mem_re(ex_mem_re),
        .ex_redirect(ex_redirect), .if_valid(if_valid),
        .mem_req(mem_req), .dmem_ack(dmem_ack),
        .stall_o(stall_o), .flush_o(flush_o),
        .dmem_err(dmem_err),
        .perf_stall_cnt(perf_stall_cnt),
        .perf_redirect_cnt(perf_redirect_cnt)
    );

    task automatic idle_in();
        rst = 1'b1;
        id_r1 = 5'd0; id_r2 = 5'd0; ex_rd = 5'd0;
        id_r1_used = 1'b0; id_r2_used = 1'b0;
        ex_mem_re = 1'b0; ex_redirect = 1'b0;
        if_valid = 1'b1; mem_req = 1'b0; dmem_ack = 1'b0;
    endtask

    task automatic push(input logic [4:0] st, input logic [4:0] fl,
                        input logic err);
        sb.push_back('{st, fl, err});
    endtask

    task automatic reset_dut();
        @(negedge clk);
        idle_in();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        @(negedge clk);
        idle_in();
        rst = 1'b0; if_valid = 1'b0; mem_req = 1'b1; ex_redirect = 1'b1;
        push(Z, Z, 1'b0);
        #1 e = sb.pop_front(); vec++;
        if ({stall_o, flush_o, dmem_err} !== e) begin
            bad++;
            $display("FAIL reset_out: got %b/%b/%b want %b/%b/%b",
                     stall_o, flush_o, dmem_err, e.st, e.fl, e.err);
        end
        @(posedge clk); #1 vec++;
        if (perf_stall_cnt !== 32'd0 || perf_redirect_cnt !== 32'd0) begin
            bad++;
            $display("FAIL reset_cnt: got %0d/%0d want 0/0",
                     perf_stall_cnt, perf_redirect_cnt);
        end
    endtask

    task automatic test_load_use();
        exp_t e;
        reset_dut();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            idle_in();
            ex_mem_re = 1'b1;
            case (i)
                0: begin ex_rd = 5'd5; id_r1 = 5'd5; id_r1_used = 1'b1;
                         push(S_LU, F_LU, 1'b0); end
                1: begin ex_rd = 5'd0; id_r1 = 5'd0; id_r1_used = 1'b1;
                         push(Z, Z, 1'b0); end
                2: begin ex_rd = 5'd7; id_r1 = 5'd3; id_r2 = 5'd7;
                         id_r1_used = 1'b1; id_r2_used = 1'b1;
                         push(S_LU, F_LU, 1'b0); end
                3: begin ex_rd = 5'd7; id_r1 = 5'd7; id_r2 = 5'd7;
                         push(Z, Z, 1'b0); end
                4: begin ex_mem_re = 1'b0; ex_rd = 5'd5; id_r1 = 5'd5;
                         id_r1_used = 1'b1; push(Z, Z, 1'b0); end
                5: begin ex_rd = 5'd9; id_r1 = 5'd9; id_r1_used = 1'b1;
                         if_valid = 1'b0; push(S_LU, F_LU, 1'b0); end
                default: begin ex_rd = 5'd9; id_r1 = 5'd8; id_r2 = 5'd10;
                         id_r1_used = 1'b1; id_r2_used = 1'b1;
                         if_valid = 1'b0; push(S_IF, F_IF, 1'b0); end
            endcase
            #1 e = sb.pop_front(); vec++;
            if ({stall_o, flush_o, dmem_err} !== e) begin
                bad++;
                $display("FAIL load_use[%0d]: got %b/%b/%b want %b/%b/%b",
                         i, stall_o, flush_o, dmem_err, e.st, e.fl, e.err);
            end
        end
        @(negedge clk);
        idle_in();
        vec++;
        if (perf_stall_cnt !== 32'd4) begin
            bad++;
            $display("FAIL load_use_cnt: got %0d want 4", perf_stall_cnt);
        end
    endtask

    task automatic test_redirect();
        exp_t e;
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle_in();
            case (i)
                0: begin ex_redirect = 1'b1; ex_mem_re = 1'b1; ex_rd = 5'd5;
                         id_r1 = 5'd5; id_r1_used = 1'b1;
                         push(Z, F_RD, 1'b0); end
                1: begin ex_redirect = 1'b1; if_valid = 1'b0;
                         push(Z, F_RD, 1'b0); end
                default: push(Z, Z, 1'b0);
            endcase
            #1 e = sb.pop_front(); vec++;
            if ({stall_o, flush_o, dmem_err} !== e) begin
                bad++;
                $display("FAIL redirect[%0d]: got %b/%b/%b want %b/%b/%b",
                         i, stall_o, flush_o, dmem_err, e.st, e.fl, e.err);
            end
            @(posedge clk); #1 vec++;
            if (perf_redirect_cnt !== 32'(i < 2 ? i + 1 : 2)) begin
                bad++;
                $display("FAIL redirect_cnt[%0d]: got %0d want %0d",
                         i, perf_redirect_cnt, (i < 2 ? i + 1 : 2));
            end
        end
        vec++;
        if (perf_stall_cnt !== 32'd0) begin
            bad++;
            $display("FAIL redirect_stall_cnt: got %0d want 0", perf_stall_cnt);
        end
    endtask

    task automatic test_dmem_wait();
        exp_t e;
        logic [2:0] rq [10] = '{3'b100, 3'b100, 3'b100, 3'b110, 3'b000,
                                3'b101, 3'b101, 3'b111, 3'b000, 3'b110};
        int kind [10] = '{1, 1, 1, 0, 0, 1, 1, 2, 0, 0};
        reset_dut();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            idle_in();
            {mem_req, dmem_ack, ex_redirect} = rq[i];
            case (kind[i])
                1:       push(S_DM, F_DM, 1'b0);
                2:       push(Z, F_RD, 1'b0);
                default: push(Z, Z, 1'b0);
            endcase
            #1 e = sb.pop_front(); vec++;
            if ({stall_o, flush_o, dmem_err} !== e) begin
                bad++;
                $display("FAIL dmem_wait[%0d]: got %b/%b/%b want %b/%b/%b",
                         i, stall_o, flush_o, dmem_err, e.st, e.fl, e.err);
            end
            if (i == 4) begin
                vec++;
                if (perf_stall_cnt !== 32'd3) begin
                    bad++;
                    $display("FAIL dmem_cnt3: got %0d want 3", perf_stall_cnt);
                end
            end
        end
        @(negedge clk);
        idle_in();
        vec++;
        if (perf_stall_cnt !== 32'd5 || perf_redirect_cnt !== 32'd1) begin
            bad++;
            $display("FAIL dmem_cnt_end: got %0d/%0d want 5/1",
                     perf_stall_cnt, perf_redirect_cnt);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        logic [1:0] rq [10] = '{2'b10, 2'b10, 2'b00, 2'b10, 2'b10,
                                2'b10, 2'b10, 2'b10, 2'b00, 2'b11};
        int kind [10] = '{1, 1, 0, 1, 1, 1, 1, 3, 0, 0};
        reset_dut();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            idle_in();
            {mem_req, dmem_ack} = rq[i];
            case (kind[i])
                1:       push(S_DM, F_DM, 1'b0);
                3:       push(Z, Z, 1'b1);
                default: push(Z, Z, 1'b0);
            endcase
            #1 e = sb.pop_front(); vec++;
            if ({stall_o, flush_o, dmem_err} !== e) begin
                bad++;
                $display("FAIL timeout[%0d]: got %b/%b/%b want %b/%b/%b",
                         i, stall_o, flush_o, dmem_err, e.st, e.fl, e.err);
            end
        end
        @(negedge clk);
        idle_in();
        vec++;
        if (perf_stall_cnt !== 32'd6) begin
            bad++;
            $display("FAIL timeout_cnt: got %0d want 6", perf_stall_cnt);
        end
    endtask

    task automatic test_fetch_wait();
        exp_t e;
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle_in();
            if_valid = (i == 2);
            if (i < 2) push(S_IF, F_IF, 1'b0);
            else       push(Z, Z, 1'b0);
            #1 e = sb.pop_front(); vec++;
            if ({stall_o, flush_o, dmem_err} !== e) begin
                bad++;
                $display("FAIL fetch_wait[%0d]: got %b/%b/%b want %b/%b/%b",
                         i, stall_o, flush_o, dmem_err, e.st, e.fl, e.err);
            end
        end
        @(negedge clk);
        vec++;
        if (perf_stall_cnt !== 32'd2) begin
            bad++;
            $display("FAIL fetch_cnt: got %0d want 2", perf_stall_cnt);
        end
    endtask

    task automatic test_reset_mid_wait();
        exp_t e;
        int kind [9] = '{1, 1, 0, 1, 1, 1, 1, 3, 0};
        reset_dut();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            idle_in();
            mem_req = (i != 8);
            rst = (i != 2);
            case (kind[i])
                1:       push(S_DM, F_DM, 1'b0);
                3:       push(Z, Z, 1'b1);
                default: push(Z, Z, 1'b0);
            endcase
            #1 e = sb.pop_front(); vec++;
            if ({stall_o, flush_o, dmem_err} !== e) begin
                bad++;
                $display("FAIL rst_wait[%0d]: got %b/%b/%b want %b/%b/%b",
                         i, stall_o, flush_o, dmem_err, e.st, e.fl, e.err);
            end
            if (i == 3) begin
                vec++;
                if (perf_stall_cnt !== 32'd0) begin
                    bad++;
                    $display("FAIL rst_wait_cnt: got %0d want 0", perf_stall_cnt);
                end
            end
        end
    endtask

    task automatic test_saturate();
        reset_dut();
        @(negedge clk);
        idle_in();
        if_valid = 1'b0;
        force dut.perf_stall_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.perf_stall_cnt;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1 vec++;
            if (perf_stall_cnt !== 32'hFFFF_FFFF) begin
                bad++;
                $display("FAIL saturate[%0d]: got %h want ffffffff",
                         i, perf_stall_cnt);
            end
        end
        @(negedge clk);
        idle_in();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle_in();
        rst = 1'b0;
        test_reset();
        test_load_use();
        test_redirect();
        test_dmem_wait();
        test_timeout();
        test_fetch_wait();
        test_reset_mid_wait();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
